// File: rtl/div_clock_period_meter_if.sv
// ---------------------------------------------------------------------------
// div_clock_period_meter_if
// Request/result handshake bundle between a divider self-check controller
// and the div_clock_period_meter.
//   i_start        1      one-cycle measurement request (meter only accepts it in IDLE)
//   i_resultAck    1      consumer accepts the result (meter only honours it in DONE)
//   o_busy         1      measurement in progress (ARM or MEAS)
//   o_resultValid  1      result available (DONE)
//   o_periodCycles CNT_W  average divided-clock period in reference cycles
//   o_highCycles   CNT_W  average high time in reference cycles
//   o_overflow     1      an accumulator saturated during the measurement
//   o_timeout      1      no divided-clock rise seen in time
// Modports: master = controller side, slave = meter side.
// ---------------------------------------------------------------------------
interface div_clock_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             i_start;
  logic             i_resultAck;
  logic             o_busy;
  logic             o_resultValid;
  logic [CNT_W-1:0] o_periodCycles;
  logic [CNT_W-1:0] o_highCycles;
  logic             o_overflow;
  logic             o_timeout;

  modport master (
    output i_start, i_resultAck,
    input  o_busy, o_resultValid, o_periodCycles, o_highCycles, o_overflow, o_timeout
  );

  modport slave (
    input  i_start, i_resultAck,
    output o_busy, o_resultValid, o_periodCycles, o_highCycles, o_overflow, o_timeout
  );
endinterface

// File: rtl/div_clock_period_meter.sv
// ---------------------------------------------------------------------------
// div_clock_period_meter
// Measures a divided clock (output of the clock dividers) in reference-clock
// cycles: average period and average high time over 2**AVG_LOG2 periods.
// Used for on-chip divider self-check; results go out over a valid/ack
// handshake on the interface.
// Ports:
//   clock     in   reference clock, all logic on posedge
//   rst       in   asynchronous, active-high reset
//   i_divIn   in   divided clock under test, asynchronous to clock
//   bus       slave modport of div_clock_period_meter_if (start/ack in,
//             busy/valid/period/high/overflow/timeout out)
// Configuration macro: PERIOD_METER_DUTY_EN
//   defined   -> high-time accumulator built, o_highCycles reports it
//   undefined -> no high accumulator, o_highCycles tied 0, overflow from
//                the total accumulator only
// ---------------------------------------------------------------------------
module div_clock_period_meter #(
  parameter int CNT_W       = 16,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     i_divIn,
  div_clock_period_meter_if.slave  bus
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic [NPER_W-1:0] LAST_PER = NPER_W'((2 ** AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sPrev;
  logic [ACC_W-1:0]       r_total;
  logic [NPER_W-1:0]      r_nper;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_ovf;

  logic                   w_s;
  logic                   w_rise;
  logic [ACC_W:0]         w_totSum;
  logic [ACC_W-1:0]       w_totNext;
  logic [ACC_W-1:0]       w_highNext;
  logic                   w_ovfNow;

  // Synchronizer chain for the asynchronous divided clock, plus the
  // previous-sample flop used for rising-edge detection.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_sPrev <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_divIn};
      r_sPrev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_sPrev;

  // Saturating next values of the accumulators; the carry out marks a
  // saturation event and feeds the sticky overflow.
  assign w_totSum  = {1'b0, r_total} + (ACC_W + 1)'(1);
  assign w_totNext = w_totSum[ACC_W] ? '1 : w_totSum[ACC_W-1:0];

`ifdef PERIOD_METER_DUTY_EN
  logic [ACC_W-1:0] r_high;
  logic [ACC_W:0]   w_highSum;

  assign w_highSum  = {1'b0, r_high} + (ACC_W + 1)'(w_s);
  assign w_highNext = w_highSum[ACC_W] ? '1 : w_highSum[ACC_W-1:0];
  assign w_ovfNow   = r_ovf | w_totSum[ACC_W] | w_highSum[ACC_W];

  // High-time accumulator: cleared when the first rise arms the window,
  // counts synchronized high samples while measuring.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_high <= '0;
    end else if (r_state == ARM && w_rise) begin
      r_high <= '0;
    end else if (r_state == MEAS) begin
      r_high <= w_highNext;
    end
  end
`else
  assign w_highNext = '0;
  assign w_ovfNow   = r_ovf | w_totSum[ACC_W];
`endif

  // Main control FSM. All handshake outputs are registered here.
  // The terminal rise uses the accumulators' next values, so the window
  // covers exactly 2**AVG_LOG2 whole periods including the rise cycle.
  // A terminal rise takes priority over a timeout hit in the same cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state            <= IDLE;
      r_total            <= '0;
      r_nper             <= '0;
      r_tmo              <= '0;
      r_ovf              <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_resultValid  <= 1'b0;
      bus.o_periodCycles <= '0;
      bus.o_highCycles   <= '0;
      bus.o_overflow     <= 1'b0;
      bus.o_timeout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            bus.o_overflow     <= 1'b0;
            bus.o_timeout      <= 1'b0;
            bus.o_periodCycles <= '0;
            bus.o_highCycles   <= '0;
            r_tmo              <= '0;
            bus.o_busy         <= 1'b1;
            r_state            <= ARM;
          end
        end
        ARM: begin
          if (w_rise) begin
            r_total <= '0;
            r_nper  <= '0;
            r_tmo   <= '0;
            r_ovf   <= 1'b0;
            r_state <= MEAS;
          end else if (r_tmo == TMO_LAST) begin
            bus.o_timeout      <= 1'b1;
            bus.o_periodCycles <= '0;
            bus.o_highCycles   <= '0;
            bus.o_busy         <= 1'b0;
            bus.o_resultValid  <= 1'b1;
            r_state            <= DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        MEAS: begin
          r_total <= w_totNext;
          r_ovf   <= w_ovfNow;
          if (w_rise && r_nper == LAST_PER) begin
            bus.o_overflow     <= w_ovfNow;
            bus.o_timeout      <= 1'b0;
            bus.o_periodCycles <= w_ovfNow ? '1 : w_totNext[ACC_W-1:AVG_LOG2];
`ifdef PERIOD_METER_DUTY_EN
            bus.o_highCycles   <= w_ovfNow ? '1 : w_highNext[ACC_W-1:AVG_LOG2];
`else
            bus.o_highCycles   <= '0;
`endif
            bus.o_busy         <= 1'b0;
            bus.o_resultValid  <= 1'b1;
            r_state            <= DONE;
          end else if (w_rise) begin
            r_nper <= r_nper + NPER_W'(1);
            r_tmo  <= '0;
          end else if (r_tmo == TMO_LAST) begin
            bus.o_timeout      <= 1'b1;
            bus.o_periodCycles <= '0;
            bus.o_highCycles   <= '0;
            bus.o_busy         <= 1'b0;
            bus.o_resultValid  <= 1'b1;
            r_state            <= DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        DONE: begin
          if (bus.i_resultAck) begin
            bus.o_resultValid <= 1'b0;
            r_state           <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
